elevator_ctrl_n: RTL and testbench

Parametrised N-floor elevator controller; the next generation of the fixed 3-floor people/door/elevator FSM trio, merged into one block.
- Latches hall and cabin calls per floor and serves them with SCAN (keep direction while calls remain ahead).
- Times door dwell and counts occupants; over-capacity alarm holds the door open.
- Sits below the system top, between the call decoders and the display and LED drivers. Runs on one clock, advanced by a slow tick enable.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elevator_occupancy.sv | 71 +++++++
 rtl/elevator_ctrl_n.sv | 224 ++++++++++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and encodings for the N-floor elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0] ENG_STOP = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b01;
    localparam logic [1:0] ENG_DOWN = 2'b10;

endpackage

// File: rtl/elevator_occupancy.sv
// Occupant counter: rising-edge detect on up/down, saturating count and
// over-capacity alarm, both registered.
module elevator_occupancy #(
    parameter int CAPACITY = 6,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    output logic [CNT_W-1:0] count,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CAPACITY + 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             up_prev_q;
    logic             down_prev_q;
    logic             up_edge_s;
    logic             down_edge_s;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             alarm_q;
    logic             alarm_d;

    // Next count and alarm; simultaneous edges cancel out.
    always_comb begin
        up_edge_s   = up & ~up_prev_q;
        down_edge_s = down & ~down_prev_q;
        count_d     = count_q;
        if (en && up_edge_s && !down_edge_s) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end else if (en && down_edge_s && !up_edge_s) begin
            if (count_q != CNT_ZERO) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
        alarm_d = (count_d > CNT_CAP);
    end

    // Edge history, counter and alarm registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            count_q     <= CNT_ZERO;
            alarm_q     <= 1'b0;
        end else begin
            up_prev_q   <= up;
            down_prev_q <= down;
            count_q     <= count_d;
            alarm_q     <= alarm_d;
        end
    end

    assign count = count_q;
    assign alarm = alarm_q;

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: call latch, SCAN scheduling FSM, door dwell
// timer and occupancy tracking. Timing advances only on tick.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int FLOORS       = 3,
    parameter int FLOOR_W      = 2,
    parameter int CAPACITY     = 6,
    parameter int CNT_W        = 3,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [FLOORS-1:0]  call_hall,
    input  logic [FLOORS-1:0]  call_cab,
    input  logic               up,
    input  logic               down,
    output logic [FLOOR_W-1:0] floor,
    output logic [1:0]         engine,
    output logic               door_open,
    output logic               alarm,
    output logic [CNT_W-1:0]   count,
    output logic [FLOORS-1:0]  pending
);

    localparam int TRV_W  = $clog2(TRAVEL_TICKS + 1);
    localparam int DOOR_W = $clog2(DOOR_TICKS + 1);

    localparam logic [TRV_W-1:0]   TRV_LOAD   = TRV_W'(TRAVEL_TICKS);
    localparam logic [TRV_W-1:0]   TRV_ONE    = TRV_W'(1);
    localparam logic [DOOR_W-1:0]  DOOR_LOAD  = DOOR_W'(DOOR_TICKS);
    localparam logic [DOOR_W-1:0]  DOOR_ONE   = DOOR_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP  = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE  = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_ZERO = FLOOR_W'(0);

    state_t              state_q, state_d;
    dir_t                dir_q, dir_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [1:0]          engine_q, engine_d;
    logic                door_q, door_d;
    logic [FLOORS-1:0]   pending_q, pending_d;
    logic [TRV_W-1:0]    travel_q, travel_d;
    logic [DOOR_W-1:0]   door_t_q, door_t_d;
    logic [FLOORS-1:0]   calls_s;
    logic [FLOORS-1:0]   clr_s;
    logic                going_up_s;
    logic                at_end_s;
    logic                alarm_s;

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (FLOOR_W'(i) > f)) begin
                r = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (FLOOR_W'(i) < f)) begin
                r = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] r;
        r    = {FLOORS{1'b0}};
        r[f] = 1'b1;
        return r;
    endfunction

    elevator_occupancy #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occupancy (
        .clk   (clk),
        .reset (reset),
        .en    (door_q),
        .up    (up),
        .down  (down),
        .count (count),
        .alarm (alarm_s)
    );

    // Scheduler, timers and call latch next-state logic.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        floor_d    = floor_q;
        engine_d   = engine_q;
        door_d     = door_q;
        travel_d   = travel_q;
        door_t_d   = door_t_q;
        clr_s      = {FLOORS{1'b0}};
        calls_s    = call_hall | call_cab;
        going_up_s = (state_q == MOVE_UP);
        at_end_s   = going_up_s ? (floor_q == FLOOR_TOP) : (floor_q == FLOOR_ZERO);
        case (state_q)
            IDLE: begin
                engine_d = ENG_STOP;
                door_d   = 1'b0;
                if (!tick) begin
                    state_d = IDLE;
                end else if (pending_q[floor_q]) begin
                    state_d  = DOOR;
                    clr_s    = onehot(floor_q);
                    door_d   = 1'b1;
                    door_t_d = DOOR_LOAD;
                end else if (any_above(pending_q, floor_q) &&
                             (dir_q == DIR_UP || !any_below(pending_q, floor_q))) begin
                    state_d  = MOVE_UP;
                    dir_d    = DIR_UP;
                    engine_d = ENG_UP;
                    travel_d = TRV_LOAD;
                end else if (any_below(pending_q, floor_q)) begin
                    state_d  = MOVE_DOWN;
                    dir_d    = DIR_DOWN;
                    engine_d = ENG_DOWN;
                    travel_d = TRV_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (!tick) begin
                    state_d = state_q;
                end else if (at_end_s) begin
                    // Defensive: never drive past the shaft ends.
                    state_d  = IDLE;
                    engine_d = ENG_STOP;
                end else if (travel_q > TRV_ONE) begin
                    travel_d = travel_q - TRV_ONE;
                end else begin
                    floor_d  = going_up_s ? (floor_q + FLOOR_ONE) : (floor_q - FLOOR_ONE);
                    travel_d = TRV_LOAD;
                    if (pending_q[floor_d]) begin
                        state_d  = DOOR;
                        clr_s    = onehot(floor_d);
                        engine_d = ENG_STOP;
                        door_d   = 1'b1;
                        door_t_d = DOOR_LOAD;
                    end else if (going_up_s ? any_above(pending_q, floor_d)
                                            : any_below(pending_q, floor_d)) begin
                        state_d = state_q;
                    end else begin
                        state_d  = IDLE;
                        engine_d = ENG_STOP;
                    end
                end
            end
            DOOR: begin
                engine_d = ENG_STOP;
                door_d   = 1'b1;
                clr_s    = onehot(floor_q);
                if (calls_s[floor_q]) begin
                    door_t_d = DOOR_LOAD;
                end else if (!tick) begin
                    door_t_d = door_t_q;
                end else if (door_t_q > DOOR_ONE) begin
                    door_t_d = door_t_q - DOOR_ONE;
                end else begin
                    // Over-capacity parks the timer at zero and keeps the door open.
                    door_t_d = {DOOR_W{1'b0}};
                    if (!alarm_s) begin
                        state_d = IDLE;
                        door_d  = 1'b0;
                    end else begin
                        state_d = DOOR;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                engine_d = ENG_STOP;
                door_d   = 1'b0;
            end
        endcase
        pending_d = (pending_q | calls_s) & ~clr_s;
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= FLOOR_ZERO;
            engine_q  <= ENG_STOP;
            door_q    <= 1'b0;
            pending_q <= {FLOORS{1'b0}};
            travel_q  <= {TRV_W{1'b0}};
            door_t_q  <= {DOOR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            engine_q  <= engine_d;
            door_q    <= door_d;
            pending_q <= pending_d;
            travel_q  <= travel_d;
            door_t_q  <= door_t_d;
        end
    end

    assign floor     = floor_q;
    assign engine    = engine_q;
    assign door_open = door_q;
    assign pending   = pending_q;
    assign alarm     = alarm_s;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Self-checking bench for elevator_ctrl_n (4 floors): directed scenarios plus
// random traffic, every cycle compared against a behavioural model.
module tb_elevator_ctrl_n;

    localparam int NF  = 4;
    localparam int CAP = 6;
    localparam int TT  = 2;
    localparam int DT  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic [NF-1:0] call_hall = '0;
    logic [NF-1:0] call_cab = '0;
    logic          up = 1'b0;
    logic          down = 1'b0;
    logic [1:0]    floor;
    logic [1:0]    engine;
    logic          door_open;
    logic          alarm;
    logic [2:0]    count;
    logic [NF-1:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int tick_per = 4;
    int up_ticks = 0;
    int door_ticks = 0;
    bit door_seen = 0;
    int stops[$];

    // behavioural model: position, motion (+1/-1/0), door and occupants
    int      m_floor, m_move, m_dir, m_trav, m_dleft, m_cnt;
    bit      m_door, m_alarm, m_pu, m_pd;
    bit [NF-1:0] m_pend;

    elevator_ctrl_n #(
        .FLOORS(NF), .FLOOR_W(2), .CAPACITY(CAP), .CNT_W(3),
        .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .call_hall(call_hall), .call_cab(call_cab),
        .up(up), .down(down), .floor(floor), .engine(engine), .door_open(door_open),
        .alarm(alarm), .count(count), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ahead(int f, int d, bit [NF-1:0] p);
        for (int j = 0; j < NF; j++) if (p[j] && (j - f) * d > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_move = 0; m_dir = 1; m_trav = 0; m_dleft = 0; m_cnt = 0;
        m_door = 0; m_alarm = 0; m_pu = 0; m_pd = 0; m_pend = '0;
    endtask

    task automatic open_door();
        m_door = 1; m_dleft = DT; m_move = 0;
    endtask

    task automatic model_step();
        bit [NF-1:0] calls, clr;
        bit old_alarm, upe, dne;
        calls = call_hall | call_cab;
        clr = '0;
        old_alarm = m_alarm;
        upe = up && !m_pu;
        dne = down && !m_pd;
        m_pu = up;
        m_pd = down;
        if (m_door && (upe != dne)) begin
            if (upe) m_cnt = (m_cnt < CAP + 1) ? m_cnt + 1 : m_cnt;
            else     m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end
        m_alarm = (m_cnt > CAP);
        if (m_door) begin
            clr[m_floor] = 1'b1;
            if (calls[m_floor]) m_dleft = DT;
            else if (tick) begin
                if (m_dleft <= 1) begin
                    m_dleft = 0;
                    if (!old_alarm) m_door = 0;
                end else m_dleft--;
            end
        end else if (m_move != 0) begin
            if (tick) begin
                if ((m_move > 0 && m_floor == NF - 1) || (m_move < 0 && m_floor == 0)) m_move = 0;
                else if (m_trav > 1) m_trav--;
                else begin
                    m_floor += m_move;
                    m_trav = TT;
                    if (m_pend[m_floor]) begin
                        clr[m_floor] = 1'b1;
                        open_door();
                    end else if (!ahead(m_floor, m_move, m_pend)) m_move = 0;
                end
            end
        end else if (tick) begin
            if (m_pend[m_floor]) begin
                clr[m_floor] = 1'b1;
                open_door();
            end else if (ahead(m_floor, 1, m_pend) && (m_dir == 1 || !ahead(m_floor, -1, m_pend))) begin
                m_move = 1; m_dir = 1; m_trav = TT;
            end else if (ahead(m_floor, -1, m_pend)) begin
                m_move = -1; m_dir = -1; m_trav = TT;
            end
        end
        m_pend = (m_pend | calls) & ~clr;
    endtask

    task automatic check_all();
        chk("floor", floor, m_floor);
        chk("engine", engine, (m_move > 0) ? 1 : ((m_move < 0) ? 2 : 0));
        chk("door_open", door_open, m_door);
        chk("count", count, m_cnt);
        chk("alarm", alarm, m_alarm);
        chk("pending", pending, m_pend);
        chk("door_engine_excl", door_open && (engine != 2'b00), 0);
    endtask

    task automatic cyc();
        tick = ((cyc_n % tick_per) == tick_per - 1);
        if (tick && door_open) door_ticks++;
        if (tick && engine == 2'b01) up_ticks++;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (door_open && !door_seen) stops.push_back(int'(floor));
        door_seen = door_open;
        cyc_n++;
    endtask

    task automatic wait_door(input logic val, input int bound, input string tag);
        int n = 0;
        while (door_open !== val && n < bound) begin
            cyc();
            n++;
        end
        chk(tag, door_open, val);
    endtask

    task automatic wait_ticks(input int t);
        int seen = 0;
        while (seen < t) begin
            cyc();
            if (tick) seen++;
        end
    endtask

    task automatic pulse_up();
        up = 1'b1; cyc(); up = 1'b0; cyc();
    endtask

    task automatic pulse_down();
        down = 1'b1; cyc(); down = 1'b0; cyc();
    endtask

    function automatic int stop_at(int i);
        return (i < stops.size()) ? stops[i] : -1;
    endfunction

    initial begin
        int n;
        // reset state, checked while reset is held
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_floor", floor, 0);
        chk("rst_engine", engine, 0);
        chk("rst_door", door_open, 0);
        chk("rst_count", count, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_pending", pending, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) cyc();

        // floor 0 to 3: engine up for 3*TT ticks then door opens
        up_ticks = 0;
        call_cab = 4'b1000; cyc(); call_cab = '0;
        wait_door(1'b1, 200, "s1_door_timeout");
        chk("s1_floor", floor, 3);
        chk("s1_pending", pending, 0);
        chk("s1_engine", engine, 0);
        chk("s1_up_ticks", up_ticks, 3 * TT);

        // return to 0, then SCAN: stops at 1, 3, then back to 0
        wait_door(1'b0, 100, "s2_close_timeout");
        call_cab = 4'b0001; cyc(); call_cab = '0;
        wait_door(1'b1, 200, "s2_home_timeout");
        chk("s2_home_floor", floor, 0);
        wait_door(1'b0, 100, "s2_close2_timeout");
        stops.delete();
        call_cab = 4'b0010; call_hall = 4'b1000; cyc(); call_cab = '0; call_hall = '0;
        n = 0;
        while (floor !== 2'd1 && n < 200) begin cyc(); n++; end
        chk("s2_reach1", floor, 1);
        call_hall = 4'b0001; cyc(); call_hall = '0;
        n = 0;
        while (stops.size() < 3 && n < 600) begin cyc(); n++; end
        chk("s2_stop0", stop_at(0), 1);
        chk("s2_stop1", stop_at(1), 3);
        chk("s2_stop2", stop_at(2), 0);

        // over-capacity at floor 2 holds the door
        wait_door(1'b0, 100, "s3_close_timeout");
        tick_per = 16;
        call_cab = 4'b0100; cyc(); call_cab = '0;
        wait_door(1'b1, 400, "s3_door_timeout");
        chk("s3_floor", floor, 2);
        repeat (7) pulse_up();
        chk("s3_count7", count, 7);
        chk("s3_alarm_on", alarm, 1);
        repeat (64) cyc();
        chk("s3_door_held", door_open, 1);
        pulse_down();
        chk("s3_count6", count, 6);
        chk("s3_alarm_off", alarm, 0);
        wait_door(1'b0, 20, "s3_close_after_alarm");

        // door closed: up edge ignored
        pulse_up();
        chk("s4_closed_up", count, 6);

        // same-floor call at door timer 1 reloads the dwell
        call_cab = 4'b0100; cyc(); call_cab = '0;
        wait_door(1'b1, 40, "s5_door_timeout");
        wait_ticks(2);
        door_ticks = 0;
        call_cab = 4'b0100; cyc(); call_cab = '0;
        chk("s5_pending_clr", pending[2], 0);
        wait_door(1'b0, 80, "s5_close_timeout");
        chk("s5_dwell_ticks", door_ticks, DT);

        // simultaneous edges, down saturation at 0
        call_cab = 4'b0100; cyc(); call_cab = '0;
        wait_door(1'b1, 40, "s4_door_timeout");
        up = 1'b1; down = 1'b1; cyc(); up = 1'b0; down = 1'b0; cyc();
        chk("s4_both_edges", count, 6);
        repeat (7) pulse_down();
        chk("s4_sat_zero", count, 0);
        repeat (2) pulse_up();
        chk("s4_count2", count, 2);
        wait_door(1'b0, 80, "s4_close_timeout");

        // async reset while moving up
        tick_per = 4;
        call_cab = 4'b1000; cyc(); call_cab = '0;
        n = 0;
        while (engine !== 2'b01 && n < 20) begin cyc(); n++; end
        chk("s6_moving", engine, 2'b01);
        repeat (3) cyc();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("s6_floor", floor, 0);
        chk("s6_engine", engine, 0);
        chk("s6_pending", pending, 0);
        chk("s6_count", count, 0);
        chk("s6_door", door_open, 0);
        chk("s6_alarm", alarm, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        door_seen = 0;
        repeat (40) cyc();
        chk("s6_no_motion", engine, 0);
        chk("s6_still_floor0", floor, 0);

        // random traffic against the model
        tick_per = 3;
        repeat (500) begin
            call_hall = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            call_cab  = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            up   = ($urandom_range(3) == 0);
            down = ($urandom_range(3) == 0);
            cyc();
        end
        call_hall = '0; call_cab = '0; up = 1'b0; down = 1'b0;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
